// File: rtl/barrier_gate_ctrl_pkg.sv
// Shared parking definitions: gate and parking-controller state codes, default
// gate timing parameters.
package barrier_gate_ctrl_pkg;

    typedef enum logic [2:0] {
        GS_HOMING  = 3'd0,
        GS_CLOSED  = 3'd1,
        GS_OPENING = 3'd2,
        GS_OPEN    = 3'd3,
        GS_CLOSING = 3'd4,
        GS_STOP    = 3'd5,
        GS_FAULT   = 3'd6
    } gate_state_e;

    typedef enum logic [1:0] {
        PK_IDLE       = 2'd0,
        PK_WAIT_GATE  = 2'd1,
        PK_PASSING    = 2'd2,
        PK_CLOSE_GATE = 2'd3
    } park_state_e;

    localparam int MOVE_TIMEOUT_DEF = 20;
    localparam int DEADTIME_DEF     = 2;
    localparam int TIMER_W          = 8;

    function automatic logic is_travel(gate_state_e s);
        return s inside {GS_HOMING, GS_OPENING, GS_CLOSING};
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Travel timer: counts cycles spent moving; flags the cycle whose count step
// would reach the timeout limit.
module gate_timer
    import barrier_gate_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               hold,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !hold)
            count <= count + 1'b1;
    end

    assign expired = enable && !hold && ((count + 1'b1) == limit);

endmodule

// File: rtl/barrier_gate_ctrl.sv
// Parking barrier gate controller: command handshake, travel supervision,
// obstruction reversal and fault/homing recovery with registered outputs.
module barrier_gate_ctrl
    import barrier_gate_ctrl_pkg::*;
#(
    parameter int MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
    parameter int DEADTIME     = DEADTIME_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_open,
    output logic       cmd_ready,
    input  logic       up_limit,
    input  logic       down_limit,
    input  logic       obstruct,
    input  logic       fault_clr,
    output logic       motor_up,
    output logic       motor_down,
    output logic       done,
    output logic       fault,
    output logic [2:0] gate_state,
    output logic [3:0] rev_count
);

    gate_state_e state, nxt;
    logic [7:0]  off_cnt, off_nxt;
    logic        accept, off_ok, expired, arrive;
    logic        up_nxt, dn_nxt, done_nxt;

    assign accept     = cmd_valid && cmd_ready;
    assign off_ok     = off_cnt >= 8'(DEADTIME);
    assign gate_state = state;

    gate_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (is_travel(nxt) && (nxt != state)),
        .enable  (is_travel(state)),
        .hold    ((state == GS_HOMING) && obstruct),
        .limit   (TIMER_W'(MOVE_TIMEOUT)),
        .expired (expired)
    );

    always_comb begin
        nxt = state;
        if (state != GS_FAULT && up_limit && down_limit)
            nxt = GS_FAULT;
        else begin
            case (state)
                GS_HOMING:  if (down_limit) nxt = GS_CLOSED;
                            else if (expired) nxt = GS_FAULT;
                GS_CLOSED:  if (!down_limit) nxt = GS_FAULT;
                            else if (accept && cmd_open) nxt = GS_OPENING;
                GS_OPEN:    if (!up_limit) nxt = GS_FAULT;
                            else if (accept && !cmd_open) nxt = GS_CLOSING;
                GS_OPENING: if (up_limit) nxt = GS_OPEN;
                            else if (expired) nxt = GS_FAULT;
                // obstruction outranks reaching the bottom limit
                GS_CLOSING: if (obstruct) nxt = GS_STOP;
                            else if (down_limit) nxt = GS_CLOSED;
                            else if (expired) nxt = GS_FAULT;
                GS_STOP:    if (off_ok) nxt = GS_OPENING;
                GS_FAULT:   if (fault_clr && off_ok) nxt = GS_HOMING;
                default:    nxt = GS_FAULT;
            endcase
        end
    end

    // off_cnt tracks consecutive motor-off cycles; any motion start that could
    // reverse direction waits until it reaches DEADTIME.
    always_comb begin
        up_nxt   = (nxt == GS_OPENING);
        dn_nxt   = (nxt == GS_CLOSING) ||
                   ((nxt == GS_HOMING) && (state == GS_HOMING) && !obstruct);
        off_nxt  = (up_nxt || dn_nxt) ? 8'd0 : (off_ok ? off_cnt : off_cnt + 8'd1);
        arrive   = ((state == GS_OPENING) && (nxt == GS_OPEN)) ||
                   ((state == GS_CLOSING) && (nxt == GS_CLOSED));
        done_nxt = arrive || (accept && (nxt == state));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= GS_HOMING;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            cmd_ready  <= 1'b0;
            rev_count  <= 4'd0;
            off_cnt    <= 8'd0;
        end else begin
            state      <= nxt;
            motor_up   <= up_nxt;
            motor_down <= dn_nxt;
            done       <= done_nxt;
            fault      <= (nxt == GS_FAULT);
            cmd_ready  <= ((nxt == GS_CLOSED) || (nxt == GS_OPEN)) &&
                          (off_nxt >= 8'(DEADTIME));
            off_cnt    <= off_nxt;
            if ((state == GS_CLOSING) && (nxt == GS_STOP) && (rev_count != 4'hF))
                rev_count <= rev_count + 4'd1;
        end
    end

endmodule

// File: tb/tb_barrier_gate_ctrl.sv
// Directed scenarios then closed-loop random traffic against a behavioural
// gate model; every cycle's outputs are compared with the model.
module tb_barrier_gate_ctrl;

    localparam int TO = 20, DT = 2;
    localparam int H = 0, CL = 1, OPG = 2, OP = 3, CLG = 4, ST = 5, FT = 6;

    logic       clk = 0, reset = 1;
    logic       cmd_valid = 0, cmd_open = 0, up_limit = 0, down_limit = 0;
    logic       obstruct = 0, fault_clr = 0;
    logic       cmd_ready, motor_up, motor_down, done, fault;
    logic [2:0] gate_state;
    logic [3:0] rev_count;

    int checks = 0, errors = 0;

    // model of the gate as seen from outside
    int ms = H, mrev = 0, tused = 0, pend = 0;
    bit mu = 0, md = 0, mdone = 0, mf = 0, mr = 0;
    bit hist[$];
    int last_dir = 0, zeros = 0;

    always #5 clk = ~clk;

    barrier_gate_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_open(cmd_open),
        .cmd_ready(cmd_ready), .up_limit(up_limit), .down_limit(down_limit),
        .obstruct(obstruct), .fault_clr(fault_clr), .motor_up(motor_up),
        .motor_down(motor_down), .done(done), .fault(fault),
        .gate_state(gate_state), .rev_count(rev_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // true when the motors have been idle for the last DT recorded cycles
    function automatic bit idle_long();
        if (hist.size() < DT) return 0;
        for (int i = 0; i < DT; i++)
            if (hist[hist.size() - 1 - i]) return 0;
        return 1;
    endfunction

    task automatic model_edge();
        int nx;
        bit acc, trav, held, expd, was_idle;
        if (reset) begin
            ms = H; mu = 0; md = 0; mdone = 0; mf = 0; mr = 0;
            mrev = 0; tused = 0; pend = 0; hist.delete();
            return;
        end
        acc      = cmd_valid && mr;
        was_idle = idle_long();
        trav     = (ms == H) || (ms == OPG) || (ms == CLG);
        held     = (ms == H) && obstruct;
        expd     = trav && !held && (tused + 1 == TO);
        nx = ms;
        if (up_limit && down_limit && ms != FT) nx = FT;
        else case (ms)
            H:   if (down_limit) nx = CL; else if (expd) nx = FT;
            CL:  if (!down_limit) nx = FT; else if (acc && cmd_open) nx = OPG;
            OP:  if (!up_limit) nx = FT; else if (acc && !cmd_open) nx = CLG;
            OPG: if (up_limit) nx = OP; else if (expd) nx = FT;
            CLG: if (obstruct) nx = ST; else if (down_limit) nx = CL; else if (expd) nx = FT;
            ST:  if (was_idle) nx = OPG;
            default: if (fault_clr && was_idle) nx = H;
        endcase
        mdone = 0;
        if (acc && nx != FT) begin
            if (nx == ms) mdone = 1; else pend = 1;
        end
        if (((ms == OPG && nx == OP) || (ms == CLG && nx == CL)) && pend > 0) begin
            mdone = 1; pend = 0;
        end
        if (nx == FT) pend = 0;
        if (ms == CLG && nx == ST && mrev < 15) mrev++;
        if ((nx == H || nx == OPG || nx == CLG) && nx != ms) tused = 0;
        else if (trav && !held) tused++;
        mu = (nx == OPG);
        md = (nx == CLG) || (nx == H && ms == H && !obstruct);
        hist.push_back(mu || md);
        if (hist.size() > 16) void'(hist.pop_front());
        mf = (nx == FT);
        mr = (nx == CL || nx == OP) && idle_long();
        ms = nx;
    endtask

    task automatic step();
        int cur;
        @(posedge clk);
        model_edge();
        #1;
        check("state", 8'(gate_state), 8'(ms));
        check("motor_up", 8'(motor_up), 8'(mu));
        check("motor_down", 8'(motor_down), 8'(md));
        check("done", 8'(done), 8'(mdone));
        check("fault", 8'(fault), 8'(mf));
        check("cmd_ready", 8'(cmd_ready), 8'(mr));
        check("rev_count", 8'(rev_count), 8'(mrev));
        check("motor_overlap", 8'(motor_up && motor_down), 8'd0);
        cur = motor_up ? 1 : (motor_down ? 2 : 0);
        if (cur == 0) zeros++;
        else begin
            if (last_dir != 0 && cur != last_dir)
                check("deadtime", 8'(zeros >= DT), 8'd1);
            last_dir = cur;
            zeros = 0;
        end
    endtask

    initial begin
        int dcnt, ucnt, scnt, pos, rst_left, r;

        repeat (3) step();

        // homing, then closed with no done
        reset = 0; dcnt = 0;
        repeat (5) begin step(); dcnt += int'(done); end
        check("homing_state", 8'(gate_state), 8'(H));
        check("homing_motor", 8'(motor_down), 8'd1);
        down_limit = 1; step(); dcnt += int'(done);
        check("homed_closed", 8'(gate_state), 8'(CL));
        step(); dcnt += int'(done);
        check("homed_ready", 8'(cmd_ready), 8'd1);
        check("homing_no_done", 8'(dcnt), 8'd0);

        // open: 8 cycles of motor_up, single done
        cmd_valid = 1; cmd_open = 1; step();
        cmd_valid = 0; down_limit = 0; ucnt = int'(motor_up);
        for (int i = 1; i < 8; i++) begin step(); ucnt += int'(motor_up); end
        up_limit = 1; step();
        check("open_up_cycles", 8'(ucnt), 8'd8);
        check("open_state", 8'(gate_state), 8'(OP));
        check("open_done", 8'(done), 8'd1);
        step();
        check("open_done_single", 8'(done), 8'd0);

        // close interrupted by obstruction on cycle 4
        cmd_valid = 1; cmd_open = 0; step();
        cmd_valid = 0; up_limit = 0;
        step(); step(); step();
        obstruct = 1; step(); obstruct = 0;
        scnt = int'(gate_state == 3'(ST) && !motor_up && !motor_down);
        step();
        scnt += int'(gate_state == 3'(ST) && !motor_up && !motor_down);
        step();
        check("stop_cycles", 8'(scnt), 8'd2);
        check("reopen_up", 8'(motor_up), 8'd1);
        check("rev_one", 8'(rev_count), 8'd1);
        step(); step();
        up_limit = 1; step();
        check("reopen_state", 8'(gate_state), 8'(OP));
        check("reopen_done", 8'(done), 8'd1);

        // close fully, then open with no up_limit until timeout
        step();
        cmd_valid = 1; cmd_open = 0; step();
        cmd_valid = 0; up_limit = 0;
        step(); step(); step();
        down_limit = 1; step(); step();
        cmd_valid = 1; cmd_open = 1; step();
        cmd_valid = 0; down_limit = 0; ucnt = int'(motor_up);
        for (int i = 0; i < 40 && !fault; i++) begin step(); ucnt += int'(motor_up); end
        check("timeout_fault", 8'(fault), 8'd1);
        check("timeout_up_cycles", 8'(ucnt), 8'(TO));
        check("fault_motors", 8'(motor_up || motor_down), 8'd0);
        fault_clr = 1; step(); step(); fault_clr = 0;
        check("fault_to_homing", 8'(gate_state), 8'(H));
        step(); step(); step();
        down_limit = 1; step();
        check("rehomed_closed", 8'(gate_state), 8'(CL));

        // both limits in CLOSED, recover, then same-direction close command
        step();
        up_limit = 1; step();
        check("both_limits_fault", 8'(fault), 8'd1);
        up_limit = 0; fault_clr = 1; step(); fault_clr = 0;
        step(); step();
        cmd_valid = 1; cmd_open = 0; step(); cmd_valid = 0;
        check("noop_close_done", 8'(done), 8'd1);
        check("noop_close_state", 8'(gate_state), 8'(CL));
        check("noop_close_motors", 8'(motor_up || motor_down), 8'd0);
        step();
        check("noop_close_single", 8'(done), 8'd0);

        // closed-loop random traffic against a simple barrier plant
        pos = 0; rst_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (rst_left > 0) begin reset = 1; rst_left--; end
            else begin
                reset = 0;
                if ($urandom_range(0, 399) == 0) rst_left = 3;
            end
            cmd_valid  = 1'($urandom_range(0, 99) < 30);
            cmd_open   = 1'($urandom_range(0, 1));
            obstruct   = 1'($urandom_range(0, 99) < 6);
            fault_clr  = 1'($urandom_range(0, 99) < 10);
            up_limit   = (pos >= 10);
            down_limit = (pos <= 0);
            r = int'($urandom_range(0, 199));
            if (r == 0) begin up_limit = 1; down_limit = 1; end
            if (r == 1) begin up_limit = 0; down_limit = 0; end
            step();
            if (mu && pos < 10) pos++;
            if (md && pos > 0) pos--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrier_gate_ctrl.md
BARRIER_GATE_CTRL -- requirements
Module: barrier_gate_ctrl

Interface
REQ-001 Parameter MOVE_TIMEOUT, default 20, is the maximum cycles a single travel (up or down) may take before fault.
REQ-002 Parameter DEADTIME, default 2, is the number of cycles both motor outputs are held low on a direction reversal.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  the gate-command request from the parking controller.
REQ-006 cmd_open  in  1  command direction: 1 = open, 0 = close; qualified by cmd_valid.
REQ-007 cmd_ready  out  1  block can accept a command this cycle.
REQ-008 up_limit, down_limit  in  1 each  barrier fully-up and fully-down limit switches.
REQ-009 obstruct  in  1  vehicle under the barrier.
REQ-010 fault_clr  in  1  operator fault-clear pulse.
REQ-011 motor_up, motor_down  out  1 each  barrier motor drive.
REQ-012 done  out  1  one-cycle completion pulse for an accepted command.
REQ-013 fault  out  1  high while in FAULT.
REQ-014 gate_state  out  3  current state code.
REQ-015 rev_count  out  4  count of obstruction reversals, saturating.

Function
REQ-016 States and codes: HOMING=0, CLOSED=1, OPENING=2, OPEN=3, CLOSING=4, STOP=5, FAULT=6; codes 7 and above map to FAULT on the next cycle.
REQ-017 A command is accepted only on a cycle where cmd_valid and cmd_ready are both 1.
REQ-018 cmd_ready is 1 only in CLOSED and OPEN; it is 0 in all other states.
REQ-019 Accepted open in CLOSED: state becomes OPENING on the next edge, and motor_up is 1 from that cycle.
REQ-020 Accepted close in OPEN: state becomes CLOSING on the next edge, and motor_down is 1 from that cycle.
REQ-021 Accepted open in OPEN, or close in CLOSED: no motion, and done pulses on the next cycle.
REQ-022 OPENING: when up_limit=1, go to OPEN with motors off, and done pulses for 1 cycle in the first OPEN cycle.
REQ-023 CLOSING: when down_limit=1 and obstruct=0, go to CLOSED with motors off, and done pulses for 1 cycle.
REQ-024 CLOSING with obstruct=1 (this has priority over down_limit):
- go to STOP with motors off;
- increment rev_count, saturating at 15.
REQ-025 STOP: hold both motors low for DEADTIME cycles, then enter OPENING; the original close command is then completed as an open (done pulses at OPEN).
REQ-026 Travel timer:
- 8-bit, cleared on entry to OPENING, CLOSING or HOMING, incremented each cycle in those states;
- when it equals MOVE_TIMEOUT before the target limit is reached, go to FAULT.
REQ-027 up_limit=1 and down_limit=1 in the same cycle in any state other than FAULT sends the block to FAULT on the next edge.
REQ-028 Limit loss: in CLOSED with down_limit=0, or in OPEN with up_limit=0, for 1 cycle, go to FAULT.
REQ-029 FAULT: motors off, fault=1, cmd_ready=0, and no done pulse; fault_clr=1 moves the block to HOMING.
REQ-030 HOMING:
- motor_down=1 while obstruct=0;
- while obstruct=1, motor_down=0 and the timer holds its value;
- down_limit=1 goes to CLOSED without a done pulse;
- timeout goes to FAULT.
REQ-031 motor_up and motor_down shall never both be 1, and any up/down transition shall pass through at least DEADTIME cycles with both at 0.
REQ-032 All outputs are registered; done is high for exactly one cycle per accepted command.

Reset
REQ-033 While reset=1 on a clock edge:
- state=HOMING, timer=0, rev_count=0;
- motor_up=0, motor_down=0, done=0, fault=0, cmd_ready=0;
- homing motion begins in the first cycle after reset deasserts.
REQ-034 Reset asserted mid-travel stops both motors at the next edge and discards any in-flight command, with no done pulse.

Structure
REQ-035 State codes and default parameter values live in the shared parking definitions include file, alongside the parking controller state codes.
REQ-036 The travel timer is one sub-module, gate_timer, with clear, enable, hold and timeout-compare ports.

Verification
REQ-037 Reset, then down_limit=1 after 5 cycles -> state goes HOMING then CLOSED, cmd_ready=1, done never pulses.
REQ-038 CLOSED, open command accepted, up_limit=1 after 8 cycles -> motor_up high for 8 cycles, then state OPEN and a single done pulse.
REQ-039 OPEN, close command accepted, obstruct=1 on cycle 4 -> motors 0 for 2 cycles in STOP, then motor_up=1, rev_count=1; up_limit -> OPEN plus done.
REQ-040 OPENING with no up_limit for 20 cycles -> FAULT with fault=1 and motors 0; fault_clr then down_limit -> CLOSED.
REQ-041 CLOSED, up_limit and down_limit both 1 -> FAULT next cycle; close command accepted in CLOSED -> done next cycle with no motor activity.
REQ-042 In all tests, a checker asserts motor_up and motor_down are never both 1, and that the reversal dead time is at least 2 cycles.
